// File: rtl/cmp_run_ctrl_pkg.sv
// Shared definitions for the CMP run controller: widths, node count, the
// default end-of-program encoding and the controller state encoding.
// No ports; imported by cmp_run_ctrl and cmp_run_ctrl_dump_seq.
package cmp_run_ctrl_pkg;

  localparam int NUM_NODES = 4;
  localparam int INST_W    = 32;
  localparam int DADDR_W   = 8;

  localparam logic [INST_W-1:0] HALT_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DUMP  = 3'd4,
    ST_DONE  = 3'd5
  } run_state_e;

  // Cores run only while instructions execute or the pipelines retire stores;
  // every other state keeps them in reset so DMEM cannot change under the dump.
  function automatic logic core_reset_for(input run_state_e s);
    return !((s == ST_RUN) || (s == ST_DRAIN));
  endfunction

  function automatic logic busy_for(input run_state_e s);
    return (s == ST_RST) || (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_DUMP);
  endfunction

endpackage

// File: rtl/cmp_run_ctrl_dump_seq.sv
// DMEM dump address sequencer.
// Ports:
//   CLK, RESET    clock and synchronous active-high reset
//   load          one-cycle pulse: start presenting addresses from 0
//   dump_ready    consumer accepts the current address
//   dump_valid    address on dump_addr is valid (registered)
//   dump_addr     current DMEM word address (registered)
//   dump_last     dump_valid on the final address (decode of registers)
//   dump_done     handshake on the final address is happening this cycle
// Handshake: an address transfers on any rising CLK edge where dump_valid and
// dump_ready are both high; dump_addr and dump_valid never change while
// dump_valid is high and dump_ready is low.
module cmp_run_ctrl_dump_seq
  import cmp_run_ctrl_pkg::*;
#(
  parameter int unsigned DUMP_DEPTH = 128
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               load,
  input  logic               dump_ready,
  output logic               dump_valid,
  output logic [DADDR_W-1:0] dump_addr,
  output logic               dump_last,
  output logic               dump_done
);

  localparam logic [DADDR_W-1:0] LAST_ADDR = DADDR_W'(DUMP_DEPTH - 1);

  assign dump_last = dump_valid && (dump_addr == LAST_ADDR);
  assign dump_done = dump_last && dump_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dump_valid <= 1'b0;
      dump_addr  <= '0;
    end else if (load) begin
      dump_valid <= 1'b1;
      dump_addr  <= '0;
    end else if (dump_valid && dump_ready) begin
      if (dump_last) begin
        // Final transfer: drop valid and park the address at 0, no wrap.
        dump_valid <= 1'b0;
        dump_addr  <= '0;
      end else begin
        dump_addr <= dump_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_run_ctrl.sv
// Run controller for the 4-node cardinal CMP. Holds the cores in reset,
// releases them, detects end-of-program (all nodes fetch HALT_WORD in the
// same cycle) or a watchdog timeout, drains the pipelines, then streams DMEM
// dump addresses to the readout path.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   start                 begin a run (honoured in IDLE and DONE only)
//   nodeN_inst_in         fetched instruction of node N
//   dump_ready            dump consumer accepts dump_addr
//   core_reset            reset to the cores
//   busy, done            run in progress / run finished
//   timeout               last run was ended by the watchdog (sticky)
//   cycle_count           RUN cycles of current/last run
//   halt_mask             registered per-node HALT_WORD compare, bit0 = node0
//   dump_valid/addr/last  dump stream; transfer on dump_valid && dump_ready
// All outputs are registered except dump_last.
module cmp_run_ctrl
  import cmp_run_ctrl_pkg::*;
#(
  parameter int unsigned       RST_CYCLES     = 5,
  parameter int unsigned       DRAIN_CYCLES   = 5,
  parameter int unsigned       DUMP_DEPTH     = 128,
  parameter int unsigned       TIMEOUT_CYCLES = 100000,
  parameter logic [INST_W-1:0] HALT_WORD      = HALT_WORD_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [INST_W-1:0]    node0_inst_in,
  input  logic [INST_W-1:0]    node1_inst_in,
  input  logic [INST_W-1:0]    node2_inst_in,
  input  logic [INST_W-1:0]    node3_inst_in,
  input  logic                 dump_ready,
  output logic                 core_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [31:0]          cycle_count,
  output logic [NUM_NODES-1:0] halt_mask,
  output logic                 dump_valid,
  output logic [DADDR_W-1:0]   dump_addr,
  output logic                 dump_last
);

  run_state_e state_q, state_d;

  // One down-counter shared by RST and DRAIN; the two never overlap.
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          cycle_count_d;
  logic                 timeout_d;
  logic [NUM_NODES-1:0] halt_mask_d;
  logic [NUM_NODES-1:0] halt_now;
  logic                 dump_load;
  logic                 dump_done;

  assign halt_now[0] = (node0_inst_in == HALT_WORD);
  assign halt_now[1] = (node1_inst_in == HALT_WORD);
  assign halt_now[2] = (node2_inst_in == HALT_WORD);
  assign halt_now[3] = (node3_inst_in == HALT_WORD);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cycle_count_d = cycle_count;
    timeout_d     = timeout;
    halt_mask_d   = halt_mask;
    dump_load     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_RST;
          cnt_d         = RST_CYCLES - 1;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
          halt_mask_d   = '0;
        end
      end
      ST_RST: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1;
      end
      ST_RUN: begin
        // The halting (or last watchdog) cycle is itself counted.
        cycle_count_d = cycle_count + 32'd1;
        halt_mask_d   = halt_now;
        if (&halt_now) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_CYCLES - 1;
        end else if (cycle_count == TIMEOUT_CYCLES - 1) begin
          state_d   = ST_DRAIN;
          cnt_d     = DRAIN_CYCLES - 1;
          timeout_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d   = ST_DUMP;
          dump_load = 1'b1;
        end else begin
          cnt_d = cnt_q - 1;
        end
      end
      ST_DUMP: begin
        if (dump_done) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // cycle-for-cycle with state_q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      halt_mask   <= '0;
      core_reset  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cycle_count <= cycle_count_d;
      timeout     <= timeout_d;
      halt_mask   <= halt_mask_d;
      core_reset  <= core_reset_for(state_d);
      busy        <= busy_for(state_d);
      done        <= (state_d == ST_DONE);
    end
  end

  cmp_run_ctrl_dump_seq #(
    .DUMP_DEPTH (DUMP_DEPTH)
  ) u_dump_seq (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (dump_load),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_last  (dump_last),
    .dump_done  (dump_done)
  );

endmodule

// File: tb/tb_cmp_run_ctrl.sv
module tb_cmp_run_ctrl;

  localparam int RST_C   = 5;
  localparam int DRAIN_C = 5;
  localparam int DEPTH   = 128;
  localparam int TO_C    = 50;
  localparam logic [31:0] HALT = 32'h0;

  typedef struct {
    logic [31:0] cyc;
    logic        to;
    logic [3:0]  mask;
    int          low;
    int          rst;
  } res_t;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] node_inst [0:3];
  logic        dump_ready = 1'b0;
  logic        core_reset, busy, done, timeout, dump_valid, dump_last;
  logic [31:0] cycle_count;
  logic [3:0]  halt_mask;
  logic [7:0]  dump_addr;

  always #5 CLK = ~CLK;

  cmp_run_ctrl #(
    .RST_CYCLES     (RST_C),
    .DRAIN_CYCLES   (DRAIN_C),
    .DUMP_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO_C),
    .HALT_WORD      (HALT)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .start         (start),
    .node0_inst_in (node_inst[0]),
    .node1_inst_in (node_inst[1]),
    .node2_inst_in (node_inst[2]),
    .node3_inst_in (node_inst[3]),
    .dump_ready    (dump_ready),
    .core_reset    (core_reset),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .cycle_count   (cycle_count),
    .halt_mask     (halt_mask),
    .dump_valid    (dump_valid),
    .dump_addr     (dump_addr),
    .dump_last     (dump_last)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0]  exp_q[$];      // {last, addr} in dump order
  res_t        exp_res_q[$];  // end-of-run summary per run
  int          n_checks = 0;
  int          n_fail = 0;
  int          runs_done = 0;
  int          hs_cnt = 0;
  int          low_cnt = 0;
  int          rst_cnt = 0;
  int          ready_mode = 0;
  logic        done_q;
  logic [31:0] sched [0:TO_C][0:3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_cycle_count"}, cycle_count, 32'd0);
    check({tag, "_halt_mask"}, 32'(halt_mask), 32'd0);
    check({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
    check({tag, "_dump_addr"}, 32'(dump_addr), 32'd0);
    check({tag, "_dump_last"}, 32'(dump_last), 32'd0);
  endtask

  // ---------------- stimulus generation and reference model ----------------
  // pat 0: random per-node halts, all four halt together first at halt_at
  //        (0 = never). pat 1: nodes 0-2 halted throughout, node3 busy for
  //        20 cycles then halted.
  task automatic build_sched(input int pat, input int halt_at);
    for (int i = 1; i <= TO_C; i++) begin
      for (int k = 0; k < 4; k++)
        sched[i][k] = ($urandom_range(0, 1) == 0) ? HALT : ($urandom | 32'h1);
      if (pat == 1) begin
        for (int k = 0; k < 3; k++) sched[i][k] = HALT;
        sched[i][3] = (i <= 20) ? ($urandom | 32'h1) : HALT;
      end else if (i == halt_at) begin
        for (int k = 0; k < 4; k++) sched[i][k] = HALT;
      end else if ((halt_at == 0) || (i < halt_at)) begin
        if ((sched[i][0] == HALT) && (sched[i][1] == HALT) &&
            (sched[i][2] == HALT) && (sched[i][3] == HALT))
          sched[i][$urandom_range(0, 3)] = $urandom | 32'h1;
      end
    end
  endtask

  // Run length is the first cycle where every node fetches HALT, else the
  // watchdog limit; the mask is the per-node halt pattern of that final cycle.
  task automatic model(output int cyc, output logic to, output logic [3:0] m);
    cyc = TO_C;
    to  = 1'b1;
    m   = '0;
    for (int i = 1; i <= TO_C; i++) begin
      for (int k = 0; k < 4; k++) m[k] = (sched[i][k] == HALT);
      if (m == 4'hF) begin
        cyc = i;
        to  = 1'b0;
        break;
      end
    end
  endtask

  // Run cycle i is sampled at the (RST_C + i)-th posedge after start is taken.
  task automatic drive_inst(input int n);
    int i;
    i = n - RST_C + 1;
    for (int k = 0; k < 4; k++) begin
      if (i < 1)          node_inst[k] = HALT;
      else if (i <= TO_C) node_inst[k] = sched[i][k];
      else                node_inst[k] = $urandom;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_run(input int pat, input int halt_at, input int rmode, input int abort_at);
    int          cyc;
    logic        to;
    logic [3:0]  m;
    res_t        r;
    int          done0;
    bit          finished;
    build_sched(pat, halt_at);
    model(cyc, to, m);
    ready_mode = rmode;
    r.cyc = 32'(cyc); r.to = to; r.mask = m; r.low = cyc + DRAIN_C; r.rst = RST_C;
    exp_res_q.push_back(r);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({(a == DEPTH - 1), 8'(a)});
    done0    = runs_done;
    finished = 1'b0;
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    drive_inst(0);
    for (int n = 1; n < 4000; n++) begin
      @(posedge CLK); #1;
      if ((abort_at >= 0) && (hs_cnt >= abort_at)) begin
        check("abort_dump_addr", 32'(dump_addr), 32'(abort_at));
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        exp_q.delete();
        exp_res_q.delete();
        check_idle("mid_dump_reset");
        @(posedge CLK); #1;
        RESET = 1'b0;
        return;
      end
      drive_inst(n);
      // A start pulse inside RUN must be ignored.
      start = ((n == RST_C + 2) && (cyc >= 3));
      if (runs_done != done0) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: done never seen within 4000 cycles (expected run of %0d)", cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK); #1;
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = 1'($urandom_range(0, 1));
        default: dump_ready = ~dump_ready;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    res_t e;
    done_q = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        low_cnt = 0;
        rst_cnt = 0;
        hs_cnt  = 0;
        done_q  = 1'b0;
      end else begin
        if (!core_reset) low_cnt++;
        if (busy && core_reset && !dump_valid) rst_cnt++;
        if (dump_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dump_unexpected: addr %0d presented, none expected", dump_addr);
          end else begin
            check("dump_addr", 32'(dump_addr), 32'(exp_q[0][7:0]));
            check("dump_last", 32'(dump_last), 32'(exp_q[0][8]));
            if (dump_ready) begin
              void'(exp_q.pop_front());
              hs_cnt++;
            end
          end
        end else begin
          check("dump_last_idle", 32'(dump_last), 32'd0);
        end
        if (done && !done_q) begin
          if (exp_res_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_unexpected: done rose with no run expected");
          end else begin
            e = exp_res_q.pop_front();
            check("cycle_count", cycle_count, e.cyc);
            check("timeout", 32'(timeout), 32'(e.to));
            check("halt_mask", 32'(halt_mask), 32'(e.mask));
            check("core_reset_low_cycles", 32'(low_cnt), 32'(e.low));
            check("rst_cycles", 32'(rst_cnt), 32'(e.rst));
            check("dump_remaining", 32'(exp_q.size()), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
            check("done_core_reset", 32'(core_reset), 32'd1);
          end
          low_cnt = 0;
          rst_cnt = 0;
          hs_cnt  = 0;
          runs_done++;
        end
        done_q = done;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 4; k++) node_inst[k] = 32'h1;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_idle("reset");
    repeat (3) @(negedge CLK);
    check_idle("idle");

    do_run(0, 10, 0, -1);       // halt after 10 RUN cycles, ready always high
    do_run(1, 0, 1, -1);        // node3 lags by 20 cycles
    do_run(0, 0, 2, -1);        // never halts: watchdog, ready toggling 1-0-1
    do_run(0, 1, 1, -1);        // halt in the very first RUN cycle
    do_run(0, TO_C, 1, -1);     // halt coincides with watchdog: halt wins
    for (int j = 0; j < 3; j++)
      do_run(0, $urandom_range(2, TO_C - 1), 1, -1);
    do_run(0, 0, 0, 40);        // watchdog run, RESET mid-dump at addr 40
    do_run(0, $urandom_range(2, TO_C - 1), 1, -1);  // clean run after reset

    repeat (5) @(negedge CLK);
    check("leftover_results", 32'(exp_res_q.size()), 32'd0);
    check("leftover_dump", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
